// File: rtl/coffee_pkg.sv
// Shared definitions for the coffee-machine controller: timer FSM states,
// default counter width and the per-phase durations in divider ticks.
package coffee_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    RUN    = ST_RUN,
    PAUSED = ST_PAUSED,
    FINISH = ST_FINISH
  } state_t;

  localparam int CNT_W_DEF = 6;

  // Phase lengths in ~6 Hz divider ticks.
  localparam logic [CNT_W_DEF-1:0] T_HEAT     = 6'd40;
  localparam logic [CNT_W_DEF-1:0] T_BREW     = 6'd25;
  localparam logic [CNT_W_DEF-1:0] T_DISPENSE = 6'd12;

  function automatic logic state_busy(input state_t s);
    return (s == RUN) || (s == PAUSED);
  endfunction

endpackage

// File: rtl/tick_sync_edge.sv
// Brings the asynchronous divider tap into the clk domain and turns each
// synchronised rising edge into a one-cycle pulse.
module tick_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic clear,
  input  logic tick_in,
  output logic tick_pulse
);

  // Fewer than two stages would leave metastability exposed.
  localparam int N_STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [N_STAGES-1:0] sync_q;
  logic                hist_q;

  // Synchroniser chain plus history flop for edge detection.
  always_ff @(posedge clk) begin
    if (clear) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[N_STAGES-2:0], tick_in};
      hist_q <= sync_q[N_STAGES-1];
    end
  end

  assign tick_pulse = sync_q[N_STAGES-1] & ~hist_q;

endmodule

// File: rtl/dispense_timer.sv
// Programmable phase countdown driven by synchronised divider ticks;
// supports pause, abort and signals expiry with a one-cycle done pulse.
module dispense_timer
  import coffee_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             tick_in,
  input  logic             start,
  input  logic [CNT_W-1:0] duration,
  input  logic             pause,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining,
  output logic             tick_pulse
);

  localparam logic [CNT_W-1:0] ZERO_C = '0;
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             busy_q, done_q;
  logic             tick_s;

  tick_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_tick_sync_edge (
    .clk       (clk),
    .clear     (clear),
    .tick_in   (tick_in),
    .tick_pulse(tick_s)
  );

  // Next-state and countdown decode.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (duration != ZERO_C) begin
            state_d     = RUN;
            remaining_d = duration;
          end else begin
            state_d     = FINISH;
            remaining_d = ZERO_C;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_d     = IDLE;
          remaining_d = ZERO_C;
        end else if (pause) begin
          // A tick coinciding with the pause request is dropped.
          state_d = PAUSED;
        end else if (tick_s) begin
          if (remaining_q == ONE_C) begin
            state_d     = FINISH;
            remaining_d = ZERO_C;
          end else begin
            remaining_d = remaining_q - ONE_C;
          end
        end else begin
          state_d = RUN;
        end
      end
      PAUSED: begin
        if (abort) begin
          state_d     = IDLE;
          remaining_d = ZERO_C;
        end else if (!pause) begin
          state_d = RUN;
        end else begin
          state_d = PAUSED;
        end
      end
      FINISH: begin
        state_d     = IDLE;
        remaining_d = ZERO_C;
      end
      default: begin
        state_d     = IDLE;
        remaining_d = ZERO_C;
      end
    endcase
  end

  // State, counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= IDLE;
      remaining_q <= ZERO_C;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      busy_q      <= state_busy(state_d);
      done_q      <= (state_d == FINISH);
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign remaining  = remaining_q;
  assign tick_pulse = tick_s;

endmodule

// File: tb/tb_dispense_timer.sv
// Directed scoreboard bench for dispense_timer: expected remaining values
// are queued when a run is started and popped as each tick is consumed.
module tb_dispense_timer;

  localparam int CNT_W = 6;

  logic             clk;
  logic             clear;
  logic             tick_in;
  logic             start;
  logic [CNT_W-1:0] duration;
  logic             pause;
  logic             abort;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] remaining;
  logic             tick_pulse;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  dispense_timer #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .clear     (clear),
    .tick_in   (tick_in),
    .start     (start),
    .duration  (duration),
    .pause     (pause),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .remaining (remaining),
    .tick_pulse(tick_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input int obs);
    if (exp_q.size() == 0) chk({tag, " (scoreboard empty)"}, obs, -1);
    else chk(tag, obs, exp_q.pop_front());
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int dur);
    duration = CNT_W'(dur);
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  // One tick_in high/low period; reports pulse and done timing within it.
  task automatic do_tick(input int n_high, input int n_low,
                         output int pulses, output int pulse_at,
                         output int done_cnt, output int done_at,
                         output int busy_at_done);
    pulses = 0; pulse_at = -1; done_cnt = 0; done_at = -1; busy_at_done = -1;
    tick_in = 1'b1;
    for (int i = 1; i <= n_high + n_low; i++) begin
      if (i == n_high + 1) tick_in = 1'b0;
      step();
      if (tick_pulse) begin
        pulses++;
        if (pulse_at < 0) pulse_at = i;
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at      = i;
          busy_at_done = int'(busy);
        end
      end
    end
  endtask

  initial begin
    int p, pa, dc, da, bd, cnt, bcnt;
    clear = 1'b1; tick_in = 1'b1; start = 1'b1; duration = 6'd5;
    pause = 1'b0; abort = 1'b0;

    // Reset with tick_in and start active
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_remaining", int'(remaining), 0);
    end
    chk("rst_tick_pulse", int'(tick_pulse), 0);
    clear = 1'b0; start = 1'b0;
    cnt = 0; bcnt = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (tick_pulse) cnt++;
      if (busy || done) bcnt++;
    end
    chk("rst_release_pulses", cnt, 1);
    chk("rst_stays_idle", bcnt, 0);
    tick_in = 1'b0;
    for (int c = 0; c < 5; c++) step();

    // Basic count of 3
    start_run(3);
    exp_q.push_back(3); exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(0);
    chk("basic_busy", int'(busy), 1);
    sb_check("basic_rem0", int'(remaining));
    for (int k = 1; k <= 3; k++) begin
      do_tick(10, 10, p, pa, dc, da, bd);
      chk("basic_pulses", p, 1);
      sb_check("basic_rem", int'(remaining));
      chk("basic_done_cnt", dc, (k == 3) ? 1 : 0);
      if (k == 3) begin
        chk("basic_done_latency", da - pa, 1);
        chk("basic_busy_at_done", bd, 0);
      end else begin
        chk("basic_busy_mid", int'(busy), 1);
      end
    end

    // Pause holds the count
    start_run(4);
    exp_q.push_back(3);
    do_tick(10, 10, p, pa, dc, da, bd);
    sb_check("pause_rem_first", int'(remaining));
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(3);
      do_tick(10, 10, p, pa, dc, da, bd);
      sb_check("pause_rem_hold", int'(remaining));
      chk("pause_busy", int'(busy), 1);
      chk("pause_no_done", dc, 0);
    end
    pause = 1'b0;
    step();
    exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(0);
    for (int k = 1; k <= 3; k++) begin
      do_tick(10, 10, p, pa, dc, da, bd);
      sb_check("pause_rem_resume", int'(remaining));
      chk("pause_done_cnt", dc, (k == 3) ? 1 : 0);
    end

    // Abort mid-run, then a one-tick run
    start_run(5);
    exp_q.push_back(4); exp_q.push_back(3);
    for (int k = 0; k < 2; k++) begin
      do_tick(10, 10, p, pa, dc, da, bd);
      sb_check("abort_rem_pre", int'(remaining));
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_rem", int'(remaining), 0);
    cnt = int'(done);
    for (int c = 0; c < 20; c++) begin
      step();
      if (done) cnt++;
    end
    chk("abort_no_done", cnt, 0);
    start_run(1);
    chk("one_rem", int'(remaining), 1);
    do_tick(10, 10, p, pa, dc, da, bd);
    chk("one_done_cnt", dc, 1);
    chk("one_rem_end", int'(remaining), 0);

    // Zero duration; start held into the FINISH cycle is ignored
    duration = 6'd0;
    start = 1'b1;
    step();
    chk("zero_done", int'(done), 1);
    chk("zero_busy", int'(busy), 0);
    chk("zero_rem", int'(remaining), 0);
    step();
    start = 1'b0;
    chk("finish_start_ignored_done", int'(done), 0);
    chk("finish_start_ignored_busy", int'(busy), 0);

    // Start while busy is ignored; abort wins over pause
    start_run(10);
    duration = 6'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_ignored_rem", int'(remaining), 10);
    chk("restart_busy", int'(busy), 1);
    exp_q.push_back(9);
    do_tick(10, 10, p, pa, dc, da, bd);
    sb_check("restart_rem_tick", int'(remaining));
    pause = 1'b1; abort = 1'b1;
    step();
    pause = 1'b0; abort = 1'b0;
    chk("abort_pause_busy", int'(busy), 0);
    chk("abort_pause_rem", int'(remaining), 0);

    // Synchroniser: short pulse and long level
    for (int c = 0; c < 5; c++) step();
    do_tick(5, 15, p, pa, dc, da, bd);
    chk("sync_short_pulses", p, 1);
    chk("sync_short_latency", pa, 2);
    do_tick(100, 10, p, pa, dc, da, bd);
    chk("sync_long_pulses", p, 1);
    chk("sync_idle_no_done", dc, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
